// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (IF) and data (DM) ports share one memory bus.
// DM normally wins; a run counter lets a waiting fetch in after MAX_DM_RUN data grants.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_DM_RUN = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_DONE,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_ERR,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  output logic              DM_GNT,
  output logic              DM_DONE,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic              DM_ERR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  // state | meaning
  // IDLE  | bus free; next edge with any request grants an owner
  // BUSY  | MEM_REQ held; waiting for MEM_ACK or timeout

  localparam int RUN_W = (MAX_DM_RUN > 0) ? $clog2(MAX_DM_RUN + 1) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic               owner_dm;
  logic [RUN_W-1:0]   run_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               pick_if;
  logic               run_full;
  logic               finish;
  logic [DATA_W-1:0]  done_data;

  always_comb begin
    run_full  = (run_cnt == RUN_W'(MAX_DM_RUN));
    pick_if   = IF_REQ && (!DM_REQ || run_full);
    // ACK wins over an expiring timer on the same edge
    finish    = MEM_ACK || (tmo_cnt == TMO_W'(1));
    done_data = (MEM_ACK && !MEM_WE) ? MEM_RDATA : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      run_cnt   <= '0;
      tmo_cnt   <= '0;
      IF_GNT    <= 1'b0;
      IF_DONE   <= 1'b0;
      IF_ERR    <= 1'b0;
      IF_RDATA  <= '0;
      DM_GNT    <= 1'b0;
      DM_DONE   <= 1'b0;
      DM_ERR    <= 1'b0;
      DM_RDATA  <= '0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      IF_GNT  <= 1'b0;
      DM_GNT  <= 1'b0;
      IF_DONE <= 1'b0;
      DM_DONE <= 1'b0;
      IF_ERR  <= 1'b0;
      DM_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (IF_REQ || DM_REQ) begin
            state   <= BUSY;
            MEM_REQ <= 1'b1;
            tmo_cnt <= TMO_W'(TIMEOUT);
            if (pick_if) begin
              owner_dm  <= 1'b0;
              IF_GNT    <= 1'b1;
              MEM_ADDR  <= IF_ADDR;
              MEM_WE    <= 1'b0;
              MEM_WDATA <= '0;
              run_cnt   <= '0;
            end else begin
              owner_dm  <= 1'b1;
              DM_GNT    <= 1'b1;
              MEM_ADDR  <= DM_ADDR;
              MEM_WE    <= DM_WE;
              MEM_WDATA <= DM_WDATA;
              if (!IF_REQ)
                run_cnt <= '0;
              else if (!run_full)
                run_cnt <= run_cnt + RUN_W'(1);
            end
          end
        end
        BUSY: begin
          if (finish) begin
            state   <= IDLE;
            MEM_REQ <= 1'b0;
            if (owner_dm) begin
              DM_DONE  <= 1'b1;
              DM_ERR   <= !MEM_ACK;
              DM_RDATA <= done_data;
            end else begin
              IF_DONE  <= 1'b1;
              IF_ERR   <= !MEM_ACK;
              IF_RDATA <= done_data;
            end
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; grant/done expectations queued at stimulus time
// and popped when the DUT pulses GNT or DONE.
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_REQ = 1'b0;
  logic [31:0] IF_ADDR = '0;
  logic        IF_GNT, IF_DONE, IF_ERR;
  logic [31:0] IF_RDATA;
  logic        DM_REQ = 1'b0;
  logic        DM_WE = 1'b0;
  logic [31:0] DM_ADDR = '0;
  logic [31:0] DM_WDATA = '0;
  logic        DM_GNT, DM_DONE, DM_ERR;
  logic [31:0] DM_RDATA;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = '0;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_DONE(IF_DONE),
    .IF_RDATA(IF_RDATA), .IF_ERR(IF_ERR),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_GNT(DM_GNT), .DM_DONE(DM_DONE), .DM_RDATA(DM_RDATA), .DM_ERR(DM_ERR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {bit dm; logic [31:0] addr; bit we; logic [31:0] wdata;} gnt_t;
  typedef struct {bit dm; bit err; logic [31:0] rdata;} done_t;
  gnt_t  gq[$];
  done_t dq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic push_gnt(input bit dm, input logic [31:0] addr, input bit we, input logic [31:0] wdata);
    gnt_t g;
    g.dm = dm; g.addr = addr; g.we = we; g.wdata = wdata;
    gq.push_back(g);
  endtask

  task automatic push_done(input bit dm, input bit err, input logic [31:0] rdata);
    done_t d;
    d.dm = dm; d.err = err; d.rdata = rdata;
    dq.push_back(d);
  endtask

  task automatic await_gnt(input string tag, input int max_cyc);
    int   waited = 0;
    gnt_t g;
    while (!(IF_GNT || DM_GNT) && waited < max_cyc) begin
      step();
      waited++;
    end
    chk({tag, "_gnt_seen"}, 64'(IF_GNT || DM_GNT), 64'd1);
    if (gq.size() == 0) begin
      chk({tag, "_gnt_queue"}, 64'd0, 64'd1);
    end else begin
      g = gq.pop_front();
      chk({tag, "_dm_gnt"}, 64'(DM_GNT), 64'(g.dm));
      chk({tag, "_if_gnt"}, 64'(IF_GNT), 64'(!g.dm));
      chk({tag, "_mem_req"}, 64'(MEM_REQ), 64'd1);
      chk({tag, "_mem_addr"}, 64'(MEM_ADDR), 64'(g.addr));
      chk({tag, "_mem_we"}, 64'(MEM_WE), 64'(g.we));
      if (g.we) chk({tag, "_mem_wdata"}, 64'(MEM_WDATA), 64'(g.wdata));
    end
  endtask

  task automatic await_done(input string tag, input int max_cyc);
    int    waited = 0;
    done_t d;
    while (!(IF_DONE || DM_DONE) && waited < max_cyc) begin
      step();
      waited++;
    end
    chk({tag, "_done_seen"}, 64'(IF_DONE || DM_DONE), 64'd1);
    if (dq.size() == 0) begin
      chk({tag, "_done_queue"}, 64'd0, 64'd1);
    end else begin
      d = dq.pop_front();
      chk({tag, "_dm_done"}, 64'(DM_DONE), 64'(d.dm));
      chk({tag, "_if_done"}, 64'(IF_DONE), 64'(!d.dm));
      chk({tag, "_err"}, 64'(d.dm ? DM_ERR : IF_ERR), 64'(d.err));
      chk({tag, "_rdata"}, 64'(d.dm ? DM_RDATA : IF_RDATA), 64'(d.rdata));
      chk({tag, "_mem_req_off"}, 64'(MEM_REQ), 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, 64'(MEM_REQ), 64'd0);
    chk({tag, "_gnts"}, 64'({IF_GNT, DM_GNT}), 64'd0);
    chk({tag, "_dones"}, 64'({IF_DONE, DM_DONE}), 64'd0);
    chk({tag, "_errs"}, 64'({IF_ERR, DM_ERR}), 64'd0);
    chk({tag, "_mem_addr"}, 64'(MEM_ADDR), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(MEM_WDATA), 64'd0);
    chk({tag, "_if_rdata"}, 64'(IF_RDATA), 64'd0);
    chk({tag, "_dm_rdata"}, 64'(DM_RDATA), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_dm;

    // reset state
    step(); step();
    chk_all_zero("reset");
    RST = 1'b0;
    step();

    // fetch read, exact latency
    IF_REQ = 1'b1; IF_ADDR = 32'h40;
    push_gnt(1'b0, 32'h40, 1'b0, '0);
    step();
    await_gnt("fetch", 0);
    IF_REQ = 1'b0;
    step();
    chk("fetch_no_early_done", 64'(IF_DONE), 64'd0);
    MEM_ACK = 1'b1; MEM_RDATA = 32'hDEADBEEF;
    push_done(1'b0, 1'b0, 32'hDEADBEEF);
    step();
    await_done("fetch", 0);
    MEM_ACK = 1'b0;
    step();

    // starvation guard: both held, 1-cycle ACK
    IF_REQ = 1'b1; IF_ADDR = 32'h200;
    DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = 32'h300;
    for (int i = 0; i < 10; i++) begin
      exp_dm = !(i == 4 || i == 9);
      push_gnt(exp_dm, exp_dm ? 32'h300 : 32'h200, 1'b0, '0);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      await_gnt($sformatf("starve%0d", i), 2);
      if (i == 9) begin
        IF_REQ = 1'b0; DM_REQ = 1'b0;
      end
      MEM_ACK = 1'b1; MEM_RDATA = 32'h1000 + i;
      push_done(!(i == 4 || i == 9), 1'b0, 32'h1000 + i);
      step();
      await_done($sformatf("starve%0d", i), 0);
      MEM_ACK = 1'b0;
      step();
    end

    // collision: DM write beats IF, IF follows after one idle cycle
    IF_REQ = 1'b1; IF_ADDR = 32'h80;
    DM_REQ = 1'b1; DM_WE = 1'b1; DM_ADDR = 32'h100; DM_WDATA = 32'h5;
    push_gnt(1'b1, 32'h100, 1'b1, 32'h5);
    push_gnt(1'b0, 32'h80, 1'b0, '0);
    step();
    await_gnt("coll_dm", 0);
    DM_REQ = 1'b0; DM_WE = 1'b0;
    MEM_ACK = 1'b1; MEM_RDATA = 32'hAAAA5555;
    push_done(1'b1, 1'b0, 32'h0);
    step();
    await_done("coll_dm", 0);
    chk("coll_idle_gap", 64'(IF_GNT), 64'd0);
    MEM_ACK = 1'b0;
    step();
    await_gnt("coll_if", 0);
    IF_REQ = 1'b0;
    MEM_ACK = 1'b1; MEM_RDATA = 32'h12345678;
    push_done(1'b0, 1'b0, 32'h12345678);
    step();
    await_done("coll_if", 0);
    MEM_ACK = 1'b0;
    step();

    // ACK on the 16th edge beats the timeout
    DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = 32'h400;
    push_gnt(1'b1, 32'h400, 1'b0, '0);
    step();
    await_gnt("tmo_ack", 0);
    DM_REQ = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("tmo_ack_early%0d", i), 64'(DM_DONE), 64'd0);
    end
    MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFE0016;
    push_done(1'b1, 1'b0, 32'hCAFE0016);
    step();
    await_done("tmo_ack", 0);
    MEM_ACK = 1'b0;
    step();

    // pure timeout: ERR=1, RDATA cleared, exactly 16 edges
    DM_REQ = 1'b1; DM_ADDR = 32'h500; MEM_RDATA = 32'hBADBAD00;
    push_gnt(1'b1, 32'h500, 1'b0, '0);
    step();
    await_gnt("tmo", 0);
    DM_REQ = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("tmo_early%0d", i), 64'(DM_DONE), 64'd0);
    end
    push_done(1'b1, 1'b1, 32'h0);
    step();
    await_done("tmo", 0);
    step();
    chk("tmo_after_err_pulse", 64'(DM_ERR), 64'd0);

    // reset mid-transaction, late ACK ignored, then normal grant
    IF_REQ = 1'b1; IF_ADDR = 32'h600;
    push_gnt(1'b0, 32'h600, 1'b0, '0);
    step();
    await_gnt("rst_pre", 0);
    IF_REQ = 1'b0;
    step();
    RST = 1'b1;
    step();
    chk_all_zero("rst_mid");
    RST = 1'b0;
    MEM_ACK = 1'b1; MEM_RDATA = 32'h55AA55AA;
    step();
    chk("late_ack_dones", 64'({IF_DONE, DM_DONE}), 64'd0);
    chk("late_ack_mem_req", 64'(MEM_REQ), 64'd0);
    chk("late_ack_if_rdata", 64'(IF_RDATA), 64'd0);
    MEM_ACK = 1'b0;
    IF_REQ = 1'b1; IF_ADDR = 32'h700;
    push_gnt(1'b0, 32'h700, 1'b0, '0);
    step();
    await_gnt("post_rst", 0);
    IF_REQ = 1'b0;
    MEM_ACK = 1'b1; MEM_RDATA = 32'h00000077;
    push_done(1'b0, 1'b0, 32'h00000077);
    step();
    await_done("post_rst", 0);
    MEM_ACK = 1'b0;
    step();

    chk("gq_drained", 64'(gq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
